// File: rtl/rgb2hsv_pipe_if.sv
// Pixel/sync bus of the RGB-to-HSV converter: video source drives the inputs,
// the converter (slave) returns HSV plus delayed syncs.
interface rgb2hsv_pipe_if #(
   parameter int DW = 8
);
   logic          ce;
   logic          de_in;
   logic          hsync_in;
   logic          vsync_in;
   logic [DW-1:0] red;
   logic [DW-1:0] green;
   logic [DW-1:0] blue;
   logic [DW-1:0] H;
   logic [DW-1:0] S;
   logic [DW-1:0] V;
   logic          de_out;
   logic          hsync_out;
   logic          vsync_out;

   modport master (
      output ce, de_in, hsync_in, vsync_in, red, green, blue,
      input  H, S, V, de_out, hsync_out, vsync_out
   );

   modport slave (
      input  ce, de_in, hsync_in, vsync_in, red, green, blue,
      output H, S, V, de_out, hsync_out, vsync_out
   );
endinterface

// File: rtl/rgb2hsv_pipe.sv
// Fully pipelined RGB-to-HSV converter, latency DW+4 enabled cycles, with
// bit-serial restoring dividers for exact floored hue and saturation.
module rgb2hsv_pipe #(
   parameter int DW         = 8,
   parameter int HUE_SCALE  = 255,
   parameter int BLANK_ZERO = 1
) (
   input logic           clk,
   input logic           rst,
   rgb2hsv_pipe_if.slave bus
);
   localparam int LAT = DW + 4;
   localparam int W   = 2 * DW + 4;
   localparam int NW  = DW + 3;
   localparam logic [W-1:0] HS_W   = W'(HUE_SCALE);
   localparam logic [W-1:0] SMAX_W = {{(W-DW){1'b0}}, {DW{1'b1}}};
   localparam logic [W-1:0] ONE_W  = {{(W-1){1'b0}}, 1'b1};

   logic [DW-1:0]  r1_q, r1_d, g1_q, g1_d, b1_q, b1_d;
   logic [LAT-1:0] de_sr_q, de_sr_d, hs_sr_q, hs_sr_d, vs_sr_q, vs_sr_d;

   logic [1:0]     sel;
   logic [DW-1:0]  pmax, pmin;
   logic [NW-1:0]  r_x, g_x, b_x, d_x, n_x;
   logic [DW-1:0]  mx2_q, mx2_d, d2_q, d2_d;
   logic [NW-1:0]  n2_q, n2_d;

   logic [NW-1:0]  d2_x, six_d;
   logic [W-1:0]   h_sh, s_sh;
   logic [DW-1:0][W-1:0] h_rem_q, h_rem_d, h_div_q, h_div_d;
   logic [DW-1:0][W-1:0] s_rem_q, s_rem_d, s_div_q, s_div_d;
   logic [DW:0][DW-1:0]  h_quo_q, h_quo_d, s_quo_q, s_quo_d, mx_q, mx_d;
   logic [DW:0]          hz_q, hz_d, sz_q, sz_d;

   logic           blank;
   logic [DW-1:0]  h_out_q, h_out_d, s_out_q, s_out_d, v_out_q, v_out_d;

   // Input capture and sync delay line
   always_comb begin
      r1_d    = r1_q;
      g1_d    = g1_q;
      b1_d    = b1_q;
      de_sr_d = de_sr_q;
      hs_sr_d = hs_sr_q;
      vs_sr_d = vs_sr_q;
      if (bus.ce) begin
         r1_d    = bus.red;
         g1_d    = bus.green;
         b1_d    = bus.blue;
         de_sr_d = {de_sr_q[LAT-2:0], bus.de_in};
         hs_sr_d = {hs_sr_q[LAT-2:0], bus.hsync_in};
         vs_sr_d = {vs_sr_q[LAT-2:0], bus.vsync_in};
      end else begin
         r1_d = r1_q;
      end
   end

   // Max/min with R>G>B tie priority; numerator folded into 0..6d-1
   always_comb begin
      if (r1_q >= g1_q && r1_q >= b1_q) begin
         sel  = 2'd0;
         pmax = r1_q;
         pmin = (g1_q < b1_q) ? g1_q : b1_q;
      end else if (g1_q >= b1_q) begin
         sel  = 2'd1;
         pmax = g1_q;
         pmin = (r1_q < b1_q) ? r1_q : b1_q;
      end else begin
         sel  = 2'd2;
         pmax = b1_q;
         pmin = (r1_q < g1_q) ? r1_q : g1_q;
      end
      r_x = {3'b000, r1_q};
      g_x = {3'b000, g1_q};
      b_x = {3'b000, b1_q};
      d_x = {3'b000, pmax - pmin};
      case (sel)
         2'd0:    n_x = (g1_q >= b1_q) ? (g_x - b_x) : (g_x + (d_x << 2) + (d_x << 1) - b_x);
         2'd1:    n_x = (d_x << 1) + b_x - r_x;
         default: n_x = (d_x << 2) + r_x - g_x;
      endcase
      mx2_d = mx2_q;
      d2_d  = d2_q;
      n2_d  = n2_q;
      if (bus.ce) begin
         mx2_d = pmax;
         d2_d  = pmax - pmin;
         n2_d  = n_x;
      end else begin
         n2_d = n2_q;
      end
   end

   // Dividend/divisor setup, then one quotient bit per stage, MSB first
   always_comb begin
      h_rem_d = h_rem_q;
      h_div_d = h_div_q;
      s_rem_d = s_rem_q;
      s_div_d = s_div_q;
      h_quo_d = h_quo_q;
      s_quo_d = s_quo_q;
      hz_d    = hz_q;
      sz_d    = sz_q;
      mx_d    = mx_q;
      d2_x    = {3'b000, d2_q};
      six_d   = (d2_x << 2) + (d2_x << 1);
      h_sh    = '0;
      s_sh    = '0;
      if (bus.ce) begin
         h_rem_d[0] = {{(W-NW){1'b0}}, n2_q} * HS_W;
         h_div_d[0] = (d2_q == '0) ? ONE_W : {{(W-NW){1'b0}}, six_d};
         s_rem_d[0] = {{(W-DW){1'b0}}, d2_q} * SMAX_W;
         s_div_d[0] = (mx2_q == '0) ? ONE_W : {{(W-DW){1'b0}}, mx2_q};
         hz_d[0]    = (d2_q == '0);
         sz_d[0]    = (mx2_q == '0);
         mx_d[0]    = mx2_q;
         h_quo_d[0] = '0;
         s_quo_d[0] = '0;
         for (int j = 1; j < DW; j++) begin
            h_sh       = h_div_q[j-1] << (DW - j);
            s_sh       = s_div_q[j-1] << (DW - j);
            h_div_d[j] = h_div_q[j-1];
            s_div_d[j] = s_div_q[j-1];
            hz_d[j]    = hz_q[j-1];
            sz_d[j]    = sz_q[j-1];
            mx_d[j]    = mx_q[j-1];
            h_quo_d[j] = h_quo_q[j-1];
            s_quo_d[j] = s_quo_q[j-1];
            if (h_rem_q[j-1] >= h_sh) begin
               h_rem_d[j]          = h_rem_q[j-1] - h_sh;
               h_quo_d[j][DW - j]  = 1'b1;
            end else begin
               h_rem_d[j] = h_rem_q[j-1];
            end
            if (s_rem_q[j-1] >= s_sh) begin
               s_rem_d[j]          = s_rem_q[j-1] - s_sh;
               s_quo_d[j][DW - j]  = 1'b1;
            end else begin
               s_rem_d[j] = s_rem_q[j-1];
            end
         end
         // Last stage only needs the LSB decision; its remainder is discarded
         h_quo_d[DW]    = h_quo_q[DW-1];
         h_quo_d[DW][0] = (h_rem_q[DW-1] >= h_div_q[DW-1]);
         s_quo_d[DW]    = s_quo_q[DW-1];
         s_quo_d[DW][0] = (s_rem_q[DW-1] >= s_div_q[DW-1]);
         hz_d[DW]       = hz_q[DW-1];
         sz_d[DW]       = sz_q[DW-1];
         mx_d[DW]       = mx_q[DW-1];
      end else begin
         h_sh = '0;
         s_sh = '0;
      end
   end

   // Output stage: degenerate-input zeroing and blanking on the aligned de
   always_comb begin
      blank   = (BLANK_ZERO != 0) && !de_sr_q[LAT-2];
      h_out_d = h_out_q;
      s_out_d = s_out_q;
      v_out_d = v_out_q;
      if (bus.ce) begin
         if (blank) begin
            h_out_d = '0;
            s_out_d = '0;
            v_out_d = '0;
         end else begin
            h_out_d = hz_q[DW] ? '0 : h_quo_q[DW];
            s_out_d = sz_q[DW] ? '0 : s_quo_q[DW];
            v_out_d = mx_q[DW];
         end
      end else begin
         v_out_d = v_out_q;
      end
   end

   // Pipeline registers, cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r1_q    <= '0;
         g1_q    <= '0;
         b1_q    <= '0;
         de_sr_q <= '0;
         hs_sr_q <= '0;
         vs_sr_q <= '0;
         mx2_q   <= '0;
         d2_q    <= '0;
         n2_q    <= '0;
         h_rem_q <= '0;
         h_div_q <= '0;
         s_rem_q <= '0;
         s_div_q <= '0;
         h_quo_q <= '0;
         s_quo_q <= '0;
         hz_q    <= '0;
         sz_q    <= '0;
         mx_q    <= '0;
         h_out_q <= '0;
         s_out_q <= '0;
         v_out_q <= '0;
      end else begin
         r1_q    <= r1_d;
         g1_q    <= g1_d;
         b1_q    <= b1_d;
         de_sr_q <= de_sr_d;
         hs_sr_q <= hs_sr_d;
         vs_sr_q <= vs_sr_d;
         mx2_q   <= mx2_d;
         d2_q    <= d2_d;
         n2_q    <= n2_d;
         h_rem_q <= h_rem_d;
         h_div_q <= h_div_d;
         s_rem_q <= s_rem_d;
         s_div_q <= s_div_d;
         h_quo_q <= h_quo_d;
         s_quo_q <= s_quo_d;
         hz_q    <= hz_d;
         sz_q    <= sz_d;
         mx_q    <= mx_d;
         h_out_q <= h_out_d;
         s_out_q <= s_out_d;
         v_out_q <= v_out_d;
      end
   end

   assign bus.H         = h_out_q;
   assign bus.S         = s_out_q;
   assign bus.V         = v_out_q;
   assign bus.de_out    = de_sr_q[LAT-1];
   assign bus.hsync_out = hs_sr_q[LAT-1];
   assign bus.vsync_out = vs_sr_q[LAT-1];
endmodule

// File: tb/tb_rgb2hsv_pipe.sv
// Self-checking bench for rgb2hsv_pipe: two instances (hue scale 255 and 180)
// share one stimulus stream and are compared against a floor-division model.
module tb_rgb2hsv_pipe;
   localparam int DW  = 8;
   localparam int LAT = DW + 4;
   localparam int OW  = 3 + 6 * DW;
   typedef logic [OW-1:0] ov_t;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   ov_t  mpipe [LAT];

   always #5 clk = ~clk;

   rgb2hsv_pipe_if #(.DW(DW)) bus ();
   rgb2hsv_pipe_if #(.DW(DW)) bus2 ();

   assign bus2.ce       = bus.ce;
   assign bus2.de_in    = bus.de_in;
   assign bus2.hsync_in = bus.hsync_in;
   assign bus2.vsync_in = bus.vsync_in;
   assign bus2.red      = bus.red;
   assign bus2.green    = bus.green;
   assign bus2.blue     = bus.blue;

   rgb2hsv_pipe #(.DW(DW), .HUE_SCALE(255), .BLANK_ZERO(1)) dut (
      .clk(clk), .rst(rst), .bus(bus.slave));
   rgb2hsv_pipe #(.DW(DW), .HUE_SCALE(180), .BLANK_ZERO(1)) dut180 (
      .clk(clk), .rst(rst), .bus(bus2.slave));

   function automatic void hsv(input int r, input int g, input int b, input int scale,
                               output int h, output int s, output int v);
      int mx, mn, d, n;
      mx = (r > g) ? r : g;
      mx = (b > mx) ? b : mx;
      mn = (r < g) ? r : g;
      mn = (b < mn) ? b : mn;
      d  = mx - mn;
      v  = mx;
      s  = (mx == 0) ? 0 : (d * ((1 << DW) - 1)) / mx;
      if (d == 0) begin
         h = 0;
      end else begin
         if (r == mx) begin
            n = g - b;
            if (n < 0) n += 6 * d;
         end else if (g == mx) begin
            n = 2 * d + b - r;
         end else begin
            n = 4 * d + r - g;
         end
         h = (n * scale) / (6 * d);
      end
   endfunction

   function automatic ov_t model_out(input logic de, input logic hs, input logic vs,
                                     input int r, input int g, input int b);
      int h, s, v, h2, s2, v2;
      hsv(r, g, b, 255, h, s, v);
      hsv(r, g, b, 180, h2, s2, v2);
      if (!de) begin
         h = 0; s = 0; v = 0; h2 = 0; s2 = 0; v2 = 0;
      end
      return {de, hs, vs, DW'(h), DW'(s), DW'(v), DW'(h2), DW'(s2), DW'(v2)};
   endfunction

   function automatic ov_t got();
      return {bus.de_out, bus.hsync_out, bus.vsync_out, bus.H, bus.S, bus.V,
              bus2.H, bus2.S, bus2.V};
   endfunction

   task automatic clear_model();
      for (int i = 0; i < LAT; i++) mpipe[i] = '0;
   endtask

   // One clock: drive at negedge, advance the model on enabled edges, sample #1 later
   task automatic step(input logic c, input logic de, input logic hs, input logic vs,
                       input int r, input int g, input int b);
      @(negedge clk);
      bus.ce       = c;
      bus.de_in    = de;
      bus.hsync_in = hs;
      bus.vsync_in = vs;
      bus.red      = DW'(r);
      bus.green    = DW'(g);
      bus.blue     = DW'(b);
      @(posedge clk);
      if (c && !rst) begin
         for (int i = LAT - 1; i > 0; i--) mpipe[i] = mpipe[i-1];
         mpipe[0] = model_out(de, hs, vs, r, g, b);
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_model();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (got() !== '0) begin
         failures++;
         $display("FAIL reset_state got=%h exp=%h", got(), ov_t'(0));
      end
      step(1'b1, 1'b1, 1'b1, 1'b1, 200, 10, 30);
      checks++;
      if (got() !== '0) begin
         failures++;
         $display("FAIL reset_hold got=%h exp=%h", got(), ov_t'(0));
      end
      @(negedge clk);
      rst     = 1'b0;
      bus.ce  = 1'b0;
   endtask

   task automatic test_directed();
      int tr  [10] = '{50, 0, 178, 200, 50, 0, 100, 112, 0, 255};
      int tg  [10] = '{100, 0, 28, 0, 0, 50, 100, 112, 0, 255};
      int tbl [10] = '{250, 50, 192, 100, 0, 0, 0, 112, 0, 255};
      int th  [10] = '{159, 170, 208, 233, 0, 85, 42, 0, 0, 0};
      int ts  [10] = '{204, 255, 217, 255, 255, 255, 255, 0, 0, 0};
      int tv  [10] = '{250, 50, 192, 200, 50, 50, 100, 112, 0, 255};
      int th2 [10] = '{112, 120, -1, -1, -1, -1, -1, -1, -1, -1};
      int k;
      for (int t = 1; t <= 10 + LAT; t++) begin
         if (t <= 10) step(1'b1, 1'b1, 1'b0, 1'b0, tr[t-1], tg[t-1], tbl[t-1]);
         else         step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
         if (t == LAT - 1) begin
            checks++;
            if (bus.de_out !== 1'b0) begin
               failures++;
               $display("FAIL latency_early de_out got=%b exp=0", bus.de_out);
            end
         end
         if (t >= LAT && t - LAT < 10) begin
            k = t - LAT;
            checks++;
            if ({bus.de_out, bus.H, bus.S, bus.V} !== {1'b1, DW'(th[k]), DW'(ts[k]), DW'(tv[k])}) begin
               failures++;
               $display("FAIL directed_%0d got de=%b hsv=(%0d,%0d,%0d) exp de=1 hsv=(%0d,%0d,%0d)",
                        k, bus.de_out, bus.H, bus.S, bus.V, th[k], ts[k], tv[k]);
            end
            if (th2[k] >= 0) begin
               checks++;
               if (bus2.H !== DW'(th2[k])) begin
                  failures++;
                  $display("FAIL directed180_%0d got H=%0d exp H=%0d", k, bus2.H, th2[k]);
               end
            end
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         step(1'b1, 1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
         checks++;
         if (got() !== mpipe[LAT-1]) begin
            failures++;
            $display("FAIL random_%0d got=%h exp=%h", i, got(), mpipe[LAT-1]);
         end
      end
   endtask

   task automatic test_ce_toggle();
      int enabled = 0;
      int cyc = 0;
      logic c;
      while (enabled < 1000) begin
         c = ($urandom_range(0, 99) >= 30);
         if (c) enabled++;
         step(c, 1'($urandom_range(0, 9) < 9), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
         cyc++;
         checks++;
         if (got() !== mpipe[LAT-1]) begin
            failures++;
            $display("FAIL ce_toggle_%0d got=%h exp=%h", cyc, got(), mpipe[LAT-1]);
         end
      end
   endtask

   task automatic test_sync_pulse();
      int cnt = 0;
      int pos = -1;
      for (int t = 0; t < LAT; t++) step(1'b1, 1'b1, 1'b0, 1'b0, 10, 20, 30);
      for (int t = 1; t <= 2 * LAT; t++) begin
         step(1'b1, 1'b1, 1'(t == 1), 1'b0, 10, 20, 30);
         if (bus.hsync_out === 1'b1) begin
            cnt++;
            pos = t;
         end
      end
      checks++;
      if (cnt !== 1 || pos !== LAT) begin
         failures++;
         $display("FAIL hsync_pulse got count=%0d at=%0d exp count=1 at=%0d", cnt, pos, LAT);
      end
   endtask

   task automatic test_blank();
      for (int t = 0; t < LAT + 2; t++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0, int'($urandom_range(1, 255)), 77, 200);
      end
      checks++;
      if ({bus.de_out, bus.H, bus.S, bus.V, bus2.H, bus2.S, bus2.V} !== '0) begin
         failures++;
         $display("FAIL blank_zero got de=%b hsv=(%0d,%0d,%0d) exp all 0", bus.de_out, bus.H, bus.S, bus.V);
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b0,
              int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
         if (i == 10) begin
            #2;
            rst = 1'b1;
            clear_model();
            #1;
            checks++;
            if (got() !== '0) begin
               failures++;
               $display("FAIL reset_async got=%h exp=%h", got(), ov_t'(0));
            end
            for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b1, 1'b1, 90, 80, 70);
            checks++;
            if (got() !== '0) begin
               failures++;
               $display("FAIL reset_held got=%h exp=%h", got(), ov_t'(0));
            end
            @(negedge clk);
            rst    = 1'b0;
            bus.ce = 1'b0;
            break;
         end
      end
      for (int t = 1; t <= LAT + 5; t++) begin
         step(1'b1, 1'b1, 1'b0, 1'b0,
              int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
         checks++;
         if (bus.de_out !== 1'(t >= LAT) || got() !== mpipe[LAT-1]) begin
            failures++;
            $display("FAIL restart_%0d got=%h exp=%h", t, got(), mpipe[LAT-1]);
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst          = 1'b1;
      bus.ce       = 1'b0;
      bus.de_in    = 1'b0;
      bus.hsync_in = 1'b0;
      bus.vsync_in = 1'b0;
      bus.red      = '0;
      bus.green    = '0;
      bus.blue     = '0;
      test_reset();
      test_directed();
      test_random();
      test_ce_toggle();
      test_sync_pulse();
      test_blank();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
